// File: rtl/ema_regbank.sv
// ema_regbank: EMA state registers, double-buffered alpha and ctrl/status.
// Shared cfg bus with registered readback; datapath has per-channel writes.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   cfg_we         cfg write strobe
//   cfg_rd_en      cfg read strobe
//   cfg_addr       cfg address (shared by read and write)
//   cfg_data_in    cfg write data
//   cfg_rd_data    readback data, one cycle after cfg_rd_en
//   cfg_rd_valid   readback valid pulse
//   reg_we         per-channel datapath write strobe
//   reg_data_in    datapath data, ch i at [i*WIDTH +: WIDTH]
//   frame_start    frame boundary pulse (auto alpha commit)
//   reg_data_out   state registers, same packing
//   alpha_out      active alpha
//   collision_out  sticky cfg/datapath collision flag
module ema_regbank #(
  parameter int WIDTH = 16,
  parameter int N_CH = 3,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h10,
  parameter logic [ADDR_W-1:0] ALPHA_ADDR = 8'h20,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = 8'h21,
  parameter logic [WIDTH-1:0] ALPHA_RST = 16'h0800
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic                    cfg_rd_en,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [WIDTH-1:0]        cfg_data_in,
  output logic [WIDTH-1:0]        cfg_rd_data,
  output logic                    cfg_rd_valid,
  input  logic [N_CH-1:0]         reg_we,
  input  logic [N_CH*WIDTH-1:0]   reg_data_in,
  input  logic                    frame_start,
  output logic [N_CH*WIDTH-1:0]   reg_data_out,
  output logic [WIDTH-1:0]        alpha_out,
  output logic                    collision_out
);

  // One extra bit so BASE_ADDR+i never wraps onto a low address.
  localparam int AW1 = ADDR_W + 1;

  logic [N_CH-1:0][WIDTH-1:0] st_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] alpha_q;
  logic pending_q;
  logic coll_q;
  logic auto_q;
  logic [WIDTH-1:0] rd_data_q;
  logic rd_valid_q;

  logic [N_CH-1:0] hit_ch;
  logic [N_CH-1:0] wr_ch;
  logic hit_alpha;
  logic hit_ctrl;
  logic wr_alpha;
  logic wr_ctrl;
  logic commit;
  logic coll_set;
  logic coll_clr;
  logic [WIDTH-1:0] ctrl_rd;
  logic [WIDTH-1:0] rd_mux;

  always_comb begin
    hit_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit_ch[i] = ({1'b0, cfg_addr} ==
                   ({1'b0, BASE_ADDR} + AW1'(i)));
    end
  end

  assign hit_alpha = (cfg_addr == ALPHA_ADDR);
  assign hit_ctrl  = (cfg_addr == CTRL_ADDR);
  assign wr_ch     = hit_ch & {N_CH{cfg_we}};
  assign wr_alpha  = cfg_we & hit_alpha;
  assign wr_ctrl   = cfg_we & hit_ctrl;

  // Datapath owns the register on a same-cycle clash.
  assign coll_set = |(wr_ch & reg_we);
  assign coll_clr = wr_ctrl & cfg_data_in[1];

  assign commit = (wr_ctrl & cfg_data_in[0]) |
                  (frame_start & auto_q & pending_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (reg_we[i]) begin
          st_q[i] <= reg_data_in[i*WIDTH +: WIDTH];
        end else if (wr_ch[i]) begin
          st_q[i] <= cfg_data_in;
        end
      end
    end
  end

  // Commit copies the pre-edge shadow, so a same-cycle
  // shadow write lands afterwards and stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= ALPHA_RST;
      alpha_q   <= ALPHA_RST;
      pending_q <= 1'b0;
    end else begin
      if (wr_alpha) begin
        shadow_q <= cfg_data_in;
      end
      if (commit) begin
        alpha_q <= shadow_q;
      end
      if (wr_alpha) begin
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= 1'b0;
      auto_q <= 1'b0;
    end else begin
      if (coll_set) begin
        coll_q <= 1'b1;
      end else if (coll_clr) begin
        coll_q <= 1'b0;
      end
      if (wr_ctrl) begin
        auto_q <= cfg_data_in[2];
      end
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[2:0] = {auto_q, coll_q, pending_q};
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_alpha: rd_mux = shadow_q;
      hit_ctrl:  rd_mux = ctrl_rd;
      (|hit_ch): begin
        for (int i = 0; i < N_CH; i++) begin
          if (hit_ch[i]) begin
            rd_mux = st_q[i];
          end
        end
      end
      default:   rd_mux = '0;
    endcase
  end

  // Mux sees pre-edge state: read-during-write returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= cfg_rd_en;
      if (cfg_rd_en) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  assign cfg_rd_data   = rd_data_q;
  assign cfg_rd_valid  = rd_valid_q;
  assign reg_data_out  = st_q;
  assign alpha_out     = alpha_q;
  assign collision_out = coll_q;

endmodule

// File: tb/tb_ema_regbank.sv
// tb_ema_regbank: directed checks for ema_regbank.
// One task per feature, inline comparisons, one summary line.
module tb_ema_regbank;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic        cfg_rd_en;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_data_in;
  logic [15:0] cfg_rd_data;
  logic        cfg_rd_valid;
  logic [2:0]  reg_we;
  logic [47:0] reg_data_in;
  logic        frame_start;
  logic [47:0] reg_data_out;
  logic [15:0] alpha_out;
  logic        collision_out;

  int errors = 0;
  int checks = 0;

  ema_regbank dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_rd_en(cfg_rd_en),
    .cfg_addr(cfg_addr),
    .cfg_data_in(cfg_data_in),
    .cfg_rd_data(cfg_rd_data),
    .cfg_rd_valid(cfg_rd_valid),
    .reg_we(reg_we),
    .reg_data_in(reg_data_in),
    .frame_start(frame_start),
    .reg_data_out(reg_data_out),
    .alpha_out(alpha_out),
    .collision_out(collision_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_we = 0;
    cfg_rd_en = 0;
    reg_we = '0;
    frame_start = 0;
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [15:0] d);
    cfg_we = 1;
    cfg_addr = a;
    cfg_data_in = d;
    step();
    idle();
  endtask

  task automatic cfg_rd(input logic [7:0] a);
    cfg_rd_en = 1;
    cfg_addr = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    cfg_addr = '0;
    cfg_data_in = '0;
    reg_data_in = '0;
    #12;
    checks++;
    if (reg_data_out !== 48'h0) begin
      errors++;
      $display("FAIL rst_regs got=%h exp=0", reg_data_out);
    end
    checks++;
    if (alpha_out !== 16'h0800) begin
      errors++;
      $display("FAIL rst_alpha got=%h exp=0800", alpha_out);
    end
    checks++;
    if ({cfg_rd_valid, collision_out, cfg_rd_data} !== 18'h0) begin
      errors++;
      $display("FAIL rst_misc got=%b/%b/%h exp=0/0/0",
               cfg_rd_valid, collision_out, cfg_rd_data);
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_writes();
    cfg_wr(8'h11, 16'h1234);
    checks++;
    if (reg_data_out[31:16] !== 16'h1234) begin
      errors++;
      $display("FAIL wr_ch1 got=%h exp=1234", reg_data_out[31:16]);
    end
    cfg_rd(8'h11);
    checks++;
    if (cfg_rd_valid !== 1'b1 || cfg_rd_data !== 16'h1234) begin
      errors++;
      $display("FAIL rd_ch1 got=%b/%h exp=1/1234",
               cfg_rd_valid, cfg_rd_data);
    end
    step();
    checks++;
    if (cfg_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_idle got=%b exp=0", cfg_rd_valid);
    end
    // read and write same address: old value returned
    cfg_we = 1;
    cfg_rd_en = 1;
    cfg_addr = 8'h11;
    cfg_data_in = 16'hBEEF;
    step();
    idle();
    checks++;
    if (cfg_rd_data !== 16'h1234 || reg_data_out[31:16] !== 16'hBEEF) begin
      errors++;
      $display("FAIL rw_same got=%h/%h exp=1234/beef",
               cfg_rd_data, reg_data_out[31:16]);
    end
  endtask

  task automatic test_collision();
    cfg_we = 1;
    cfg_addr = 8'h10;
    cfg_data_in = 16'hAAAA;
    reg_we = 3'b001;
    reg_data_in = 48'h0000_0000_5555;
    step();
    idle();
    checks++;
    if (reg_data_out[15:0] !== 16'h5555 || collision_out !== 1'b1) begin
      errors++;
      $display("FAIL collide got=%h/%b exp=5555/1",
               reg_data_out[15:0], collision_out);
    end
    cfg_rd(8'h21);
    checks++;
    if (cfg_rd_data !== 16'h0002) begin
      errors++;
      $display("FAIL coll_status got=%h exp=0002", cfg_rd_data);
    end
    cfg_wr(8'h21, 16'h0002);
    checks++;
    if (collision_out !== 1'b0) begin
      errors++;
      $display("FAIL coll_clear got=%b exp=0", collision_out);
    end
  endtask

  task automatic test_alpha_manual();
    cfg_wr(8'h20, 16'h0400);
    checks++;
    if (alpha_out !== 16'h0800) begin
      errors++;
      $display("FAIL alpha_shadow got=%h exp=0800", alpha_out);
    end
    cfg_rd(8'h21);
    checks++;
    if (cfg_rd_data !== 16'h0001) begin
      errors++;
      $display("FAIL alpha_pend got=%h exp=0001", cfg_rd_data);
    end
    cfg_rd(8'h20);
    checks++;
    if (cfg_rd_data !== 16'h0400) begin
      errors++;
      $display("FAIL alpha_rd got=%h exp=0400", cfg_rd_data);
    end
    // auto is off: a frame boundary must not commit
    frame_start = 1;
    step();
    idle();
    checks++;
    if (alpha_out !== 16'h0800) begin
      errors++;
      $display("FAIL alpha_noauto got=%h exp=0800", alpha_out);
    end
    cfg_wr(8'h21, 16'h0001);
    checks++;
    if (alpha_out !== 16'h0400) begin
      errors++;
      $display("FAIL alpha_commit got=%h exp=0400", alpha_out);
    end
    cfg_rd(8'h21);
    checks++;
    if (cfg_rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL alpha_pend0 got=%h exp=0000", cfg_rd_data);
    end
  endtask

  task automatic test_alpha_auto();
    cfg_wr(8'h21, 16'h0004);
    cfg_wr(8'h20, 16'h0200);
    checks++;
    if (alpha_out !== 16'h0400) begin
      errors++;
      $display("FAIL auto_hold got=%h exp=0400", alpha_out);
    end
    frame_start = 1;
    step();
    idle();
    checks++;
    if (alpha_out !== 16'h0200) begin
      errors++;
      $display("FAIL auto_commit got=%h exp=0200", alpha_out);
    end
    cfg_rd(8'h21);
    checks++;
    if (cfg_rd_data !== 16'h0004) begin
      errors++;
      $display("FAIL auto_status got=%h exp=0004", cfg_rd_data);
    end
    frame_start = 1;
    step();
    idle();
    checks++;
    if (alpha_out !== 16'h0200) begin
      errors++;
      $display("FAIL auto_nopend got=%h exp=0200", alpha_out);
    end
    // shadow write in the commit cycle: old shadow goes active
    cfg_wr(8'h20, 16'h0300);
    cfg_we = 1;
    cfg_addr = 8'h20;
    cfg_data_in = 16'h0500;
    frame_start = 1;
    step();
    idle();
    checks++;
    if (alpha_out !== 16'h0300) begin
      errors++;
      $display("FAIL same_cyc got=%h exp=0300", alpha_out);
    end
    cfg_rd(8'h21);
    checks++;
    if (cfg_rd_data !== 16'h0005) begin
      errors++;
      $display("FAIL same_pend got=%h exp=0005", cfg_rd_data);
    end
    cfg_rd(8'h20);
    checks++;
    if (cfg_rd_data !== 16'h0500) begin
      errors++;
      $display("FAIL same_shadow got=%h exp=0500", cfg_rd_data);
    end
    frame_start = 1;
    step();
    idle();
    checks++;
    if (alpha_out !== 16'h0500) begin
      errors++;
      $display("FAIL same_next got=%h exp=0500", alpha_out);
    end
  endtask

  task automatic test_decode();
    cfg_rd(8'h13);
    checks++;
    if (cfg_rd_valid !== 1'b1 || cfg_rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL rd_unmapped got=%b/%h exp=1/0000",
               cfg_rd_valid, cfg_rd_data);
    end
    cfg_wr(8'h13, 16'hFFFF);
    checks++;
    if (reg_data_out !== 48'h0000_BEEF_5555) begin
      errors++;
      $display("FAIL wr_unmapped got=%h exp=0000beef5555",
               reg_data_out);
    end
    reg_we = 3'b111;
    reg_data_in = 48'hC003_B002_A001;
    step();
    idle();
    checks++;
    if (reg_data_out !== 48'hC003_B002_A001) begin
      errors++;
      $display("FAIL dp_all got=%h exp=c003b002a001", reg_data_out);
    end
    checks++;
    if (collision_out !== 1'b0) begin
      errors++;
      $display("FAIL dp_nocoll got=%b exp=0", collision_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [3];
    exp_q[0] = 16'hA001;
    exp_q[1] = 16'hB002;
    exp_q[2] = 16'hC003;
    cfg_rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      cfg_addr = 8'h10 + 8'(i);
      step();
      checks++;
      if (cfg_rd_valid !== 1'b1 || cfg_rd_data !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_%0d got=%b/%h exp=1/%h",
                 i, cfg_rd_valid, cfg_rd_data, exp_q[i]);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    cfg_wr(8'h20, 16'h0700);
    cfg_we = 1;
    cfg_addr = 8'h12;
    cfg_data_in = 16'h1111;
    reg_we = 3'b100;
    reg_data_in = 48'h2222_0000_0000;
    step();
    cfg_we = 0;
    cfg_rd_en = 1;
    cfg_addr = 8'h21;
    step();
    checks++;
    if (collision_out !== 1'b1 || cfg_rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got=%b/%b exp=1/1",
               collision_out, cfg_rd_valid);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (reg_data_out !== 48'h0 || alpha_out !== 16'h0800) begin
      errors++;
      $display("FAIL mid_rst got=%h/%h exp=0/0800",
               reg_data_out, alpha_out);
    end
    checks++;
    if ({cfg_rd_valid, collision_out, cfg_rd_data} !== 18'h0) begin
      errors++;
      $display("FAIL mid_rst_misc got=%b/%b/%h exp=0/0/0",
               cfg_rd_valid, collision_out, cfg_rd_data);
    end
    idle();
    @(negedge clk);
    rst_n = 1;
    step();
    cfg_rd(8'h21);
    checks++;
    if (cfg_rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL pend_lost got=%h exp=0000", cfg_rd_data);
    end
    cfg_rd(8'h20);
    checks++;
    if (cfg_rd_data !== 16'h0800) begin
      errors++;
      $display("FAIL shadow_rst got=%h exp=0800", cfg_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_writes();
    test_collision();
    test_alpha_manual();
    test_alpha_auto();
    test_decode();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
